// File: rtl/ldl_fifo_rd_stream.sv
// FIFO read-side streamer: turns a fixed-latency RAM read path into a
// first-word-fall-through valid/ready stream. Optional perf counters: LDL_RDS_PERF_EN.
module ldl_fifo_rd_stream #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int BUF    = RD_LAT + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty,
    output logic                      re,
    input  logic [DW-1:0]             rdata,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [DW-1:0]             o_data,
    output logic [$clog2(BUF+1)-1:0]  occ
`ifdef LDL_RDS_PERF_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [15:0]               starve_cnt
`endif
);
    localparam int OW = $clog2(BUF + 1);
    localparam int PW = (BUF > 1) ? $clog2(BUF) : 1;
    localparam logic [OW-1:0] OCC_MAX  = OW'(BUF);
    localparam logic [PW-1:0] PTR_LAST = PW'(BUF - 1);

    logic [RD_LAT-1:0] in_flight;
    logic [DW-1:0]     mem [BUF];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [OW-1:0]     count;
    logic [OW-1:0]     occ_q;
    logic              fire;
    logic              pop;
    logic              push;

    // Reads are issued only when the buffer plus in-flight words leave room,
    // or a pop this cycle frees a slot; reset holds the request low.
    assign pop     = o_valid & o_ready;
    assign re      = rst & ~empty & ((occ_q < OCC_MAX) | pop);
    assign fire    = re & ~empty;
    assign push    = in_flight[RD_LAT-1];
    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign occ     = occ_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_flight <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            occ_q     <= '0;
            for (int i = 0; i < BUF; i++) begin
                mem[i] <= '0;
            end
        end else begin
            in_flight[0] <= fire;
            for (int i = 1; i < RD_LAT; i++) begin
                in_flight[i] <= in_flight[i-1];
            end

            if (push) begin
                mem[wr_ptr] <= rdata;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end

            if (push & ~pop) begin
                count <= count + OW'(1);
            end else if (pop & ~push) begin
                count <= count - OW'(1);
            end

            // Only accepted reads are counted, never a raw request against a stale empty.
            if (fire & ~pop) begin
                occ_q <= occ_q + OW'(1);
            end else if (pop & ~fire) begin
                occ_q <= occ_q - OW'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) occ_q <= OCC_MAX);

`ifdef LDL_RDS_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (o_valid & ~o_ready & (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (~o_valid & o_ready & empty & (starve_cnt != 16'hFFFF)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
